j1_prog_loader: RTL and testbench

Program memory plus serial boot loader that sits directly upstream of the j1 core and drives its `instr` input from `pc`. It accepts a framed byte stream from a UART RX byte interface and writes 16-bit words into instruction RAM. While not running, it feeds the core `16'h0000` (jump 0), so the core parks at `pc=0` with no stack effect. After a valid frame it releases the core by serving RAM contents.

---
 rtl/j1_prog_loader_pkg.sv | 26 ++
 rtl/j1_prog_ram.sv | 31 +++
 rtl/j1_prog_loader.sv | 152 +++++++++++++++
 tb/tb_j1_prog_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/j1_prog_loader_pkg.sv
// ============================================================================
// j1_prog_loader_pkg : shared constants and loader state encoding for j1.
// Revision 1.0
// ============================================================================
`default_nettype none

package j1_prog_loader_pkg;

    localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
    localparam logic [15:0] NOP_JUMP0     = 16'h0000;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_LO  = 4'd1,
        ST_LEN_HI  = 4'd2,
        ST_DATA_LO = 4'd3,
        ST_DATA_HI = 4'd4,
        ST_CSUM    = 4'd5,
        ST_VERIFY  = 4'd6,
        ST_RUN     = 4'd7,
        ST_ERROR   = 4'd8
    } ld_state_e;

endpackage

`default_nettype wire

// File: rtl/j1_prog_ram.sv
// ============================================================================
// j1_prog_ram : 16-bit instruction RAM, synchronous write, asynchronous read.
// Revision 1.0
// ============================================================================
`default_nettype none

module j1_prog_ram #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem_q [0:(2**ADDR_W)-1];

    // Contents deliberately survive reset so a partially loaded image persists.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/j1_prog_loader.sv
// ============================================================================
// j1_prog_loader : framed serial boot loader and program memory for the j1 core.
// Revision 1.0
// ============================================================================
`default_nettype none

module j1_prog_loader
    import j1_prog_loader_pkg::*;
#(
    parameter int         ADDR_W = 13,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            rx_ready,
    input  logic [12:0]     pc,
    output logic [15:0]     instr,
    output logic            running,
    output logic            load_err,
    output logic [ADDR_W:0] words_loaded
);

    localparam logic [16:0] DEPTH = 17'(2**ADDR_W);

    ld_state_e         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        rxcsum_q, rxcsum_d;
    logic [ADDR_W:0]   words_q, words_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   addr_inc;
    logic              ram_we;
    logic [15:0]       ram_rdata;

    assign rx_ready = (state_q != ST_VERIFY);
    assign accept   = rx_valid & rx_ready;
    assign len_full = {rx_data, len_q[7:0]};
    assign addr_inc = addr_q + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            addr_q   <= '0;
            lo_q     <= '0;
            csum_q   <= '0;
            rxcsum_q <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            lo_q     <= lo_d;
            csum_q   <= csum_d;
            rxcsum_q <= rxcsum_d;
            words_q  <= words_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        lo_d     = lo_q;
        csum_d   = csum_q;
        rxcsum_d = rxcsum_q;
        words_d  = words_q;
        ram_we   = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (accept && rx_data == MAGIC) begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d   = {len_q[15:8], rx_data};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'h0000 || {1'b0, len_full} > DEPTH) begin
                        state_d = ST_ERROR;
                    end else begin
                        addr_d  = '0;
                        csum_d  = 8'h00;
                        state_d = ST_DATA_LO;
                    end
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    ram_we  = 1'b1;
                    csum_d  = csum_q ^ rx_data;
                    addr_d  = addr_inc;
                    state_d = (16'(addr_inc) == len_q) ? ST_CSUM : ST_DATA_LO;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    rxcsum_d = rx_data;
                    state_d  = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (rxcsum_q == csum_q) begin
                    words_d = len_q[ADDR_W:0];
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Core fetches in the same cycle it presents pc, so the read path is purely combinational.
    j1_prog_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (addr_q[ADDR_W-1:0]),
        .wdata_i ({rx_data, lo_q}),
        .raddr_i (pc[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign running      = (state_q == ST_RUN);
    assign load_err     = (state_q == ST_ERROR);
    assign words_loaded = words_q;
    assign instr        = running ? ram_rdata : NOP_JUMP0;

endmodule

`default_nettype wire

// File: tb/tb_j1_prog_loader.sv
// ============================================================================
// tb_j1_prog_loader : randomized self-checking bench against a frame-level model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_j1_prog_loader;

    localparam int AW    = 13;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic [12:0]   pc = 13'd0;
    logic [15:0]   instr;
    logic          running;
    logic          load_err;
    logic [AW:0]   words_loaded;

    always #5 clk = ~clk;

    j1_prog_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .pc           (pc),
        .instr        (instr),
        .running      (running),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mmem   [DEPTH];
    bit          mvalid [DEPTH];
    bit          exp_run = 1'b0;
    bit          exp_err = 1'b0;
    int          exp_words = 0;
    logic [15:0] fw [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int n;
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        do begin
            acc = rx_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 50);
        rx_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_running"}, {31'd0, running}, {31'd0, exp_run});
        chk({tag, "_err"}, {31'd0, load_err}, {31'd0, exp_err});
        chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    endtask

    task automatic check_instr(input int p);
        @(negedge clk);
        pc = 13'(p);
        #1;
        if (!exp_run) chk("instr_parked", {16'd0, instr}, 32'd0);
        else if (mvalid[p]) chk("instr_ram", {16'd0, instr}, {16'd0, mmem[p]});
    endtask

    // Expected outcome is derived from the whole frame: length legality, words, XOR.
    task automatic send_frame(input logic [15:0] len, input logic [7:0] cx,
                              input bit gaps, input bit hold);
        logic [7:0] cs;
        cs = 8'h00;
        foreach (fw[i]) cs ^= fw[i][7:0] ^ fw[i][15:8];
        cs ^= cx;
        send_byte(8'hA5, gaps);
        exp_run = 1'b0;
        exp_err = 1'b0;
        pc = 13'($urandom);
        #1;
        chk("magic_parked", {31'd0, running}, 32'd0);
        chk("magic_instr", {16'd0, instr}, 32'd0);
        chk("magic_err_clr", {31'd0, load_err}, 32'd0);
        send_byte(len[7:0], gaps);
        send_byte(len[15:8], gaps);
        if (len == 16'd0 || int'(len) > DEPTH) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                send_byte(fw[i][7:0], gaps);
                send_byte(fw[i][15:8], gaps);
                mmem[i]   = fw[i];
                mvalid[i] = 1'b1;
            end
            send_byte(cs, gaps);
            chk("verify_ready", {31'd0, rx_ready}, 32'd0);
            if (hold) begin
                rx_valid = 1'b1;
                rx_data  = 8'hA5;
            end
            @(negedge clk);
            rx_valid = 1'b0;
            if (cx == 8'h00) begin
                exp_run   = 1'b1;
                exp_words = int'(len);
            end else begin
                exp_err = 1'b1;
            end
        end
        check_status("frame");
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ln;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        check_status("rst");
        rst_n = 1'b1;
        @(negedge clk);

        fw = '{16'h8005, 16'h0001};
        send_frame(16'd2, 8'h00, 1'b0, 1'b0);
        check_instr(0);
        check_instr(1);

        fw = '{16'h1234};
        send_frame(16'd1, 8'h26, 1'b0, 1'b0);
        check_instr(0);
        check_instr(1);

        fw.delete();
        send_frame(16'h0000, 8'h00, 1'b0, 1'b0);
        send_frame(16'h2001, 8'h00, 1'b0, 1'b0);
        send_frame(16'hFFFF, 8'h00, 1'b0, 1'b0);
        check_instr(0);

        fw = '{16'h8005, 16'h0001};
        send_frame(16'd2, 8'h00, 1'b1, 1'b1);
        check_instr(0);
        check_instr(1);

        fw = '{16'h55AA};
        send_frame(16'd1, 8'h00, 1'b0, 1'b0);
        check_instr(0);
        check_instr(1);

        // Abandon a reload between data bytes: first word lands, second does not.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hFE, 1'b0);
        mmem[0] = 16'hBEEF;
        rst_n = 1'b0;
        exp_run = 1'b0;
        exp_err = 1'b0;
        exp_words = 0;
        #1;
        check_status("midrst");
        chk("midrst_ready", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        fw = '{16'h0F0F};
        send_frame(16'd1, 8'h00, 1'b0, 1'b0);
        check_instr(0);
        check_instr(1);

        for (int f = 0; f < 8; f++) begin
            ln = 16'($urandom_range(1, 8));
            fw.delete();
            for (int i = 0; i < int'(ln); i++) fw.push_back(16'($urandom));
            send_frame(ln, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                       1'($urandom), 1'($urandom));
            for (int p = 0; p < 10; p++) check_instr(p);
        end

        fw.delete();
        for (int i = 0; i < DEPTH; i++) fw.push_back(16'($urandom));
        send_frame(16'(DEPTH), 8'h00, 1'b0, 1'b0);
        check_instr(0);
        check_instr(DEPTH / 2);
        check_instr(DEPTH - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
